// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle subsystem: game states, lanes, sprite selects
// and spawn geometry defaults.
package obstacle_pkg;

    typedef enum logic [3:0] {
        GS_TITLE = 4'd0,
        GS_PLAY  = 4'd1,
        GS_PAUSE = 4'd2,
        GS_FAIL1 = 4'd3,
        GS_FAIL2 = 4'd4
    } game_state_e;

    typedef enum logic [1:0] {
        LANE_HIGH = 2'd0,
        LANE_MID  = 2'd1,
        LANE_LOW  = 2'd2
    } lane_e;

    localparam logic [3:0] SPR_CACTUS_SMALL = 4'd0;
    localparam logic [3:0] SPR_CACTUS_PAIR  = 4'd1;
    localparam logic [3:0] SPR_CACTUS_LARGE = 4'd2;
    localparam logic [3:0] SPR_ROCK         = 4'd3;
    localparam logic [3:0] SPR_BIRD_LOW     = 4'd4;
    localparam logic [3:0] SPR_BIRD_HIGH    = 4'd5;

    localparam int DEF_X_SPAWN = 780;
    localparam int DEF_X_END   = 80;

    // Width of a type field holding n distinct types (at least one bit).
    function automatic int type_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic lane_e type_lane(input logic [3:0] kind);
        case (kind)
            4'd0, 4'd1, 4'd2: return LANE_LOW;
            4'd3, 4'd4:       return LANE_MID;
            default:          return LANE_HIGH;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_pool_if.sv
// Control strobes and per-slot outputs of the obstacle pool, grouped for port passing.
interface obstacle_pool_if
    import obstacle_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
    parameter int NUM_TYPES = 6,
    parameter int XW        = 10
);
    localparam int TW = type_width(NUM_TYPES);

    logic                    run;
    logic                    clear;
    logic                    tick_move;
    logic                    tick_spawn;
    logic                    tick_speed;
    logic [12:0]             rand_val;
    logic [NUM_SLOTS-1:0]    slot_busy;
    logic [NUM_SLOTS*XW-1:0] slot_x;
    logic [NUM_SLOTS*TW-1:0] slot_type;
    logic [7:0]              speed;
    logic                    spawn_pulse;

    modport master (
        output run, clear, tick_move, tick_spawn, tick_speed, rand_val,
        input  slot_busy, slot_x, slot_type, speed, spawn_pulse
    );

    modport slave (
        input  run, clear, tick_move, tick_spawn, tick_speed, rand_val,
        output slot_busy, slot_x, slot_type, speed, spawn_pulse
    );

endinterface

// File: rtl/obstacle_slot.sv
// One obstacle slot: busy/x/type registers with load, scroll and retire.
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int XW      = 10,
    parameter int TW      = 3,
    parameter int X_SPAWN = DEF_X_SPAWN,
    parameter int X_END   = DEF_X_END
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          run,
    input  logic          move,
    input  logic          load,
    input  logic [TW-1:0] load_kind,
    output logic          busy,
    output logic [XW-1:0] x,
    output logic [TW-1:0] kind
);
    localparam logic [XW-1:0] XS = XW'(X_SPAWN);
    localparam logic [XW-1:0] XE = XW'(X_END);

    logic retire;
    assign retire = busy && (x <= XE);

    // Retire beats load and move; load beats move so a fresh slot starts at XS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            x    <= XS;
            kind <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            x    <= XS;
            kind <= '0;
        end else if (run) begin
            if (retire) begin
                busy <= 1'b0;
                x    <= XS;
            end else if (load) begin
                busy <= 1'b1;
                x    <= XS;
                kind <= load_kind;
            end else if (move && busy) begin
                x    <= x - XW'(1);
            end
        end
    end

endmodule

// File: rtl/obstacle_pool.sv
// Obstacle scheduler: spawn cooldown, slot allocation, scroll pacing and speed ramp.
// Optional spawn gap check enabled by defining OBSTACLE_MIN_GAP_EN.
module obstacle_pool
    import obstacle_pkg::*;
#(
    parameter int NUM_SLOTS  = 3,
    parameter int NUM_TYPES  = 6,
    parameter int XW         = 10,
    parameter int X_SPAWN    = DEF_X_SPAWN,
    parameter int X_END      = DEF_X_END,
    parameter int SPEED_INIT = 200,
    parameter int SPEED_STEP = 20,
    parameter int SPEED_MIN  = 40,
    parameter int RAMP_TICKS = 180,
    parameter int MIN_GAP    = 120
) (
    input logic            CLK,
    input logic            RESET,
    obstacle_pool_if.slave bus
);
    localparam int TW = type_width(NUM_TYPES);

    logic [7:0]           move_cnt, cooldown, ramp_cnt, speed_q;
    logic                 spawn_q;
    logic [NUM_SLOTS-1:0] busy, load;
    logic [XW-1:0]        xs    [NUM_SLOTS];
    logic [TW-1:0]        kinds [NUM_SLOTS];
    logic                 active, move_ev, spawn_try, found, gap_block, spawn_fire;
    logic [2:0]           alloc_idx;
    logic [TW-1:0]        raw_kind, new_kind;
    logic [8:0]           speed_diff;
    logic [7:0]           speed_ramped;
    logic                 unused_rand;

    assign active    = bus.run & ~bus.clear;
    assign move_ev   = active & bus.tick_move & (move_cnt >= speed_q);
    assign spawn_try = active & bus.tick_spawn & (cooldown >= speed_q);

    assign raw_kind    = bus.rand_val[TW-1:0];
    assign new_kind    = (raw_kind >= TW'(NUM_TYPES)) ? raw_kind - TW'(NUM_TYPES) : raw_kind;
    assign unused_rand = ^bus.rand_val;

    // Nine-bit difference: the borrow bit flags an underflow below zero.
    assign speed_diff   = {1'b0, speed_q} - 9'(SPEED_STEP);
    assign speed_ramped = (speed_diff[8] || (speed_diff < 9'(SPEED_MIN))) ? 8'(SPEED_MIN)
                                                                         : speed_diff[7:0];

    always_comb begin
        found     = 1'b0;
        alloc_idx = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!busy[i] && !found) begin
                found     = 1'b1;
                alloc_idx = 3'(i);
            end
        end
    end

`ifdef OBSTACLE_MIN_GAP_EN
    localparam logic [XW-1:0] XS = XW'(X_SPAWN);
    logic [2:0] newest_q;

    always_comb begin
        gap_block = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (newest_q == 3'(i))
                gap_block = busy[i] && ((XS - xs[i]) < XW'(MIN_GAP));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            newest_q <= '0;
        else if (bus.clear)
            newest_q <= '0;
        else if (spawn_fire)
            newest_q <= alloc_idx;
    end
`else
    logic unused_gap;
    assign gap_block  = 1'b0;
    assign unused_gap = ^XW'(MIN_GAP);
`endif

    assign spawn_fire = spawn_try & found & ~gap_block;

    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++)
            load[i] = spawn_fire && (alloc_idx == 3'(i));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            move_cnt <= '0;
            cooldown <= '0;
            ramp_cnt <= '0;
            speed_q  <= 8'(SPEED_INIT);
            spawn_q  <= 1'b0;
        end else if (bus.clear) begin
            move_cnt <= '0;
            cooldown <= '0;
            ramp_cnt <= '0;
            speed_q  <= 8'(SPEED_INIT);
            spawn_q  <= 1'b0;
        end else begin
            spawn_q <= spawn_fire;
            if (bus.run) begin
                if (bus.tick_move)
                    move_cnt <= move_ev ? '0 : move_cnt + 8'd1;
                // A failed attempt leaves cooldown parked at the threshold.
                if (bus.tick_spawn) begin
                    if (spawn_fire)
                        cooldown <= '0;
                    else if (cooldown < speed_q)
                        cooldown <= cooldown + 8'd1;
                end
                if (bus.tick_speed) begin
                    if (ramp_cnt >= 8'(RAMP_TICKS - 1)) begin
                        ramp_cnt <= '0;
                        speed_q  <= speed_ramped;
                    end else begin
                        ramp_cnt <= ramp_cnt + 8'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        obstacle_slot #(
            .XW      (XW),
            .TW      (TW),
            .X_SPAWN (X_SPAWN),
            .X_END   (X_END)
        ) u_slot (
            .clk       (CLK),
            .rst       (RESET),
            .clear     (bus.clear),
            .run       (bus.run),
            .move      (move_ev),
            .load      (load[g]),
            .load_kind (new_kind),
            .busy      (busy[g]),
            .x         (xs[g]),
            .kind      (kinds[g])
        );
    end

    logic [NUM_SLOTS*XW-1:0] x_packed;
    logic [NUM_SLOTS*TW-1:0] kind_packed;

    always_comb begin
        x_packed    = '0;
        kind_packed = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            x_packed[i*XW +: XW]    = xs[i];
            kind_packed[i*TW +: TW] = kinds[i];
        end
    end

    assign bus.slot_busy   = busy;
    assign bus.slot_x      = x_packed;
    assign bus.slot_type   = kind_packed;
    assign bus.speed       = speed_q;
    assign bus.spawn_pulse = spawn_q;

endmodule
